// File: rtl/ram_access_ctrl.sv
// Load/store front end for a single-port synchronous RAM: accepts one request,
// issues it to the RAM for one cycle, then returns an aligned/extended response.
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 10
`endif

module ram_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = `RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_we,
  input  logic [31:0]           ram_dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [1:0]  state, state_nxt;
  logic        reg_we, reg_unsigned, reg_illegal;
  logic [1:0]  reg_size, reg_lane;
  logic        accept, illegal;
  logic [3:0]  we_enc, ram_we_nxt;
  logic [31:0] din_enc;
  logic        rsp_valid_nxt, rsp_err_nxt;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Legality of the incoming request
  always_comb begin
    illegal = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    case (req_size)
      SIZE_BYTE: ;
      SIZE_HALF: if (req_addr[0]) illegal = 1'b1;
      2'b10:     if (req_addr[1:0] != 2'b00) illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  // Byte-enable and lane-replicated store data for the incoming request
  always_comb begin
    case (req_size)
      SIZE_BYTE: begin
        we_enc  = 4'b0001 << req_addr[1:0];
        din_enc = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        we_enc  = req_addr[1] ? 4'b1100 : 4'b0011;
        din_enc = {2{req_wdata[15:0]}};
      end
      default: begin
        we_enc  = 4'b1111;
        din_enc = req_wdata;
      end
    endcase
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt     = state;
    ram_we_nxt    = 4'b0000;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = ISSUE;
          ram_we_nxt = (req_we && !illegal) ? we_enc : 4'b0000;
        end
      end
      ISSUE: begin
        state_nxt     = RESP;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = reg_illegal;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ram_we       <= 4'b0000;
      ram_addr     <= '0;
      ram_din      <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      reg_we       <= 1'b0;
      reg_unsigned <= 1'b0;
      reg_illegal  <= 1'b0;
      reg_size     <= 2'b00;
      reg_lane     <= 2'b00;
    end else begin
      state     <= state_nxt;
      ram_we    <= ram_we_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      if (accept) begin
        reg_we       <= req_we;
        reg_unsigned <= req_unsigned;
        reg_illegal  <= illegal;
        reg_size     <= req_size;
        reg_lane     <= req_addr[1:0];
        ram_addr     <= req_addr[ADDR_WIDTH+1:2];
        ram_din      <= din_enc;
      end
    end
  end

  // RAM data only arrives in RESP, so the load formatter sits after the RAM output
  always_comb begin
    byte_lane = ram_dout[{reg_lane, 3'b000} +: 8];
    half_lane = reg_lane[1] ? ram_dout[31:16] : ram_dout[15:0];
    rsp_rdata = 32'd0;
    if (state == RESP && !reg_we && !reg_illegal) begin
      case (reg_size)
        SIZE_BYTE: rsp_rdata = {{24{!reg_unsigned && byte_lane[7]}}, byte_lane};
        SIZE_HALF: rsp_rdata = {{16{!reg_unsigned && half_lane[15]}}, half_lane};
        default:   rsp_rdata = ram_dout;
      endcase
    end
  end

endmodule
